// File: rtl/status_display_driver_pkg.sv
// Shared definitions for the status display driver: FSM state encoding,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and a digit-split helper.
package status_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ALARM = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Units digit of a 0..15 count; the tens digit is simply (v >= 10).
  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

endpackage

// File: rtl/status_display_driver_if.sv
// Bundle between the counter chain and the display driver.
//   cnt_in/cnt_valid : count sample and its strobe (towards the driver)
//   seg/an/leds/alarm: display outputs (from the driver)
// master = the environment feeding counts, slave = the driver.
interface status_display_driver_if;
  logic [3:0] cnt_in;
  logic       cnt_valid;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] leds;
  logic       alarm;

  modport master (output cnt_in, cnt_valid, input seg, an, leds, alarm);
  modport slave  (input cnt_in, cnt_valid, output seg, an, leds, alarm);
endinterface

// File: rtl/status_display_driver_seg7_decoder.sv
// Combinational 4-bit digit to active-low 7-segment decoder.
//   digit : 0..9 decoded to standard patterns, 10..15 shown blank
//   seg   : {g,f,e,d,c,b,a}, active-low
module status_display_driver_seg7_decoder
  import status_display_driver_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/status_display_driver.sv
// Status display driver: captures the 4-bit elapsed-time count and shows it
// in decimal on a 2-digit multiplexed 7-segment display plus 4 LEDs. At or
// above ALARM_VALUE the display blinks until the count returns to 0.
//   clk, reset : system clock, synchronous active-high reset
//   bus.slave  : cnt_in/cnt_valid in; seg/an (active-low), leds, alarm out
module status_display_driver
  import status_display_driver_pkg::*;
#(
  parameter int SCAN_DIV    = 6000,
  parameter int BLINK_DIV   = 3000000,
  parameter int ALARM_VALUE = 10
) (
  input  logic               clk,
  input  logic               reset,
  status_display_driver_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]         ALARM_TH   = 4'(ALARM_VALUE);

  logic [3:0]         cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic               digit_sel_q, digit_sel_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [6:0]         seg_q, seg_d;
  logic [1:0]         an_q, an_d;
  logic [3:0]         leds_q, leds_d;
  logic               alarm_q, alarm_d;

  logic               tens;
  logic [3:0]         digit;
  logic [6:0]         dec_seg;

  status_display_driver_seg7_decoder u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  assign tens  = (cnt_q >= 4'd10);
  // Outputs are registered from the *next* scan/state values so that the
  // registered display always agrees with the registered state.
  assign digit = digit_sel_d ? {3'b000, tens} : units_of(cnt_q);

  always_comb begin
    cnt_d = bus.cnt_valid ? bus.cnt_in : cnt_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q >= ALARM_TH)  state_d = ST_ALARM;
        else if (cnt_q != 4'd0) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (cnt_q == 4'd0)          state_d = ST_IDLE;
        else if (cnt_q >= ALARM_TH) state_d = ST_ALARM;
      end
      ST_ALARM: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Scan counter free-runs regardless of state.
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_sel_d = ~digit_sel_q;
    end

    // The entry cycle into ALARM is index 0 of phase 0, so the "on" phase
    // lasts exactly BLINK_DIV cycles after every entry.
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (state_d == ST_ALARM && state_q == ST_ALARM) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_ph_d  = blink_ph_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end
    end

    seg_d = dec_seg;
    an_d  = digit_sel_d ? 2'b01 : 2'b10;
    if (digit_sel_d && !tens) begin
      seg_d = SEG_BLANK;
      an_d  = 2'b11;
    end

    leds_d = 4'h0;
    case (state_d)
      ST_COUNT: leds_d = cnt_q;
      ST_ALARM: begin
        if (blink_ph_d) begin
          seg_d = SEG_BLANK;
          an_d  = 2'b11;
        end else begin
          leds_d = 4'hF;
        end
      end
      default: leds_d = 4'h0;
    endcase

    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      state_q     <= ST_IDLE;
      scan_cnt_q  <= '0;
      digit_sel_q <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= 2'b11;
      leds_q      <= 4'h0;
      alarm_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      leds_q      <= leds_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.leds  = leds_q;
  assign bus.alarm = alarm_q;

endmodule
